// File: rtl/ps2_mouse_packet.sv
// Assembles 3-byte PS/2 mouse movement packets from the byte receiver's output stream.
// Resynchronises on a first byte with bit 3 clear and on an inter-byte timeout.
module ps2_mouse_packet #(
  parameter int TIMEOUT = 150000,
  parameter int TW      = 18
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_data,
  output logic [8:0] xm,
  output logic [8:0] ym,
  output logic [2:0] btnm,
  output logic [1:0] ovf,
  output logic       m_done_tick,
  output logic       sync_err,
  output logic [7:0] err_cnt
);

  typedef enum logic [1:0] {B1, B2, B3, DONE} state_t;

  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  // First byte kept without its always-one bit 3: {yovf, xovf, ysign, xsign, btn[2:0]}
  logic [6:0]    b1_q, b1_d;
  logic [7:0]    b2_q, b2_d;
  logic [8:0]    xm_q, xm_d, ym_q, ym_d;
  logic [2:0]    btnm_q, btnm_d;
  logic [1:0]    ovf_q, ovf_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [7:0]    err_cnt_q, err_cnt_d;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    b1_d    = b1_q;
    b2_d    = b2_q;
    xm_d    = xm_q;
    ym_d    = ym_q;
    btnm_d  = btnm_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      B1: begin
        if (rx_done_tick && en) begin
          if (rx_data[3]) begin
            b1_d    = {rx_data[7:4], rx_data[2:0]};
            timer_d = '0;
            state_d = B2;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      B2, B3: begin
        // An arriving byte takes priority over an expiring timer.
        if (rx_done_tick) begin
          timer_d = '0;
          if (state_q == B2) begin
            b2_d    = rx_data;
            state_d = B3;
          end else begin
            xm_d    = {b1_q[3], b2_q};
            ym_d    = {b1_q[4], rx_data};
            btnm_d  = b1_q[2:0];
            ovf_d   = b1_q[6:5];
            done_d  = 1'b1;
            state_d = DONE;
          end
        end else if (timer_q == TLAST) begin
          timer_d = '0;
          err_d   = 1'b1;
          state_d = B1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      DONE: state_d = B1;
      default: state_d = B1;
    endcase
  end

  assign err_cnt_d = (err_d && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= B1;
      timer_q   <= '0;
      b1_q      <= '0;
      b2_q      <= '0;
      xm_q      <= '0;
      ym_q      <= '0;
      btnm_q    <= '0;
      ovf_q     <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      b1_q      <= b1_d;
      b2_q      <= b2_d;
      xm_q      <= xm_d;
      ym_q      <= ym_d;
      btnm_q    <= btnm_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign xm          = xm_q;
  assign ym          = ym_q;
  assign btnm        = btnm_q;
  assign ovf         = ovf_q;
  assign m_done_tick = done_q;
  assign sync_err    = err_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_ps2_mouse_packet.sv
// Scoreboard bench for ps2_mouse_packet: a packet-level model predicts decoded packets
// and sync errors from byte arrival times; a monitor checks every m_done_tick.
module tb_ps2_mouse_packet;

  localparam int TIMEOUT = 16;
  localparam int TW      = 5;

  logic       clk = 1'b0;
  logic       reset, en, rx_done_tick;
  logic [7:0] rx_data;
  logic [8:0] xm, ym;
  logic [2:0] btnm;
  logic [1:0] ovf;
  logic       m_done_tick, sync_err;
  logic [7:0] err_cnt;

  ps2_mouse_packet #(.TIMEOUT(TIMEOUT), .TW(TW)) dut (
    .clk(clk), .reset(reset), .en(en), .rx_done_tick(rx_done_tick), .rx_data(rx_data),
    .xm(xm), .ym(ym), .btnm(btnm), .ovf(ovf),
    .m_done_tick(m_done_tick), .sync_err(sync_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [8:0] xm;
    logic [8:0] ym;
    logic [2:0] btn;
    logic [1:0] ovf;
    int         cyc;
  } pkt_t;

  pkt_t sb[$];
  pkt_t last_pkt;

  int checks = 0;
  int errors = 0;

  // Packet-level model: bytes collected so far, time of the last accepted byte.
  logic [7:0] m_bytes[$];
  int         m_last;
  int         exp_sync  = 0;
  int         exp_errcnt = 0;
  int         sync_seen = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_err();
    exp_sync++;
    if (exp_errcnt < 255) exp_errcnt++;
  endtask

  task automatic model_expire(input int now);
    if (m_bytes.size() > 0 && (now - m_last) > TIMEOUT) begin
      model_err();
      m_bytes.delete();
    end
  endtask

  task automatic model_byte(input logic [7:0] d, input logic e, input int now);
    pkt_t p;
    int   xv, yv;
    model_expire(now);
    if (m_bytes.size() == 0) begin
      if (!e) return;
      if (d[3]) begin
        m_bytes.push_back(d);
        m_last = now;
      end else begin
        model_err();
      end
    end else if (m_bytes.size() == 1) begin
      m_bytes.push_back(d);
      m_last = now;
    end else begin
      xv = m_bytes[0][4] ? int'(m_bytes[1]) - 256 : int'(m_bytes[1]);
      yv = m_bytes[0][5] ? int'(d) - 256 : int'(d);
      p.xm  = 9'(xv);
      p.ym  = 9'(yv);
      p.btn = m_bytes[0][2:0];
      p.ovf = m_bytes[0][7:6];
      p.cyc = now + 1;
      sb.push_back(p);
      last_pkt = p;
      m_bytes.delete();
    end
  endtask

  // Monitor: pops the scoreboard on each packet tick and counts sync_err pulses.
  always @(negedge clk) begin
    if (!reset) begin
      if (m_done_tick) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got m_done_tick at cycle %0d, expected none", cyc);
        end else begin
          pkt_t e;
          e = sb.pop_front();
          check("xm", int'(xm), int'(e.xm));
          check("ym", int'(ym), int'(e.ym));
          check("btnm", int'(btnm), int'(e.btn));
          check("ovf", int'(ovf), int'(e.ovf));
          check("done_cycle", cyc, e.cyc);
          $display("packet: xm=%03h ym=%03h btn=%b ovf=%b at cycle %0d", xm, ym, btnm, ovf, cyc);
        end
      end
      if (sync_err) sync_seen++;
    end
  end

  task automatic send(input logic [7:0] d, input int gap);
    @(negedge clk);
    rx_done_tick = 1'b1;
    rx_data      = d;
    model_byte(d, en, cyc);
    @(negedge clk);
    rx_done_tick = 1'b0;
    repeat (gap - 2) @(negedge clk);
  endtask

  task automatic checkpoint(input string tag);
    repeat (TIMEOUT + 4) @(negedge clk);
    model_expire(cyc);
    @(posedge clk);
    #1;
    check({tag, "_sync_err_count"}, sync_seen, exp_sync);
    check({tag, "_err_cnt"}, int'(err_cnt), exp_errcnt);
    check({tag, "_pending_packets"}, sb.size(), 0);
    check({tag, "_hold_xm"}, int'(xm), int'(last_pkt.xm));
    check({tag, "_hold_ym"}, int'(ym), int'(last_pkt.ym));
    check({tag, "_hold_btn_ovf"}, int'({btnm, ovf}), int'({last_pkt.btn, last_pkt.ovf}));
    $display("checkpoint %s: sync_err=%0d err_cnt=%0d", tag, sync_seen, err_cnt);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    rx_done_tick = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_bytes.delete();
    exp_errcnt = 0;
    last_pkt = '{default: '0};
    #1;
    check("reset_xm", int'(xm), 0);
    check("reset_ym", int'(ym), 0);
    check("reset_btn_ovf", int'({btnm, ovf}), 0);
    check("reset_ticks", int'({m_done_tick, sync_err}), 0);
    check("reset_err_cnt", int'(err_cnt), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "global timeout");
  end

  initial begin
    logic [7:0] d;
    reset = 1'b1;
    en = 1'b0;
    rx_done_tick = 1'b0;
    rx_data = 8'h00;
    last_pkt = '{default: '0};
    m_last = 0;
    repeat (3) @(posedge clk);
    do_reset();

    en = 1'b1;
    send(8'h09, 3); send(8'h05, 3); send(8'hFB, 3);
    checkpoint("basic");

    send(8'h5A, 4); send(8'h80, 2); send(8'h10, 5);
    checkpoint("neg_x_ovf");

    send(8'h05, 3); send(8'h08, 3); send(8'h01, 3); send(8'h02, 3);
    checkpoint("resync");

    send(8'h08, 3);
    checkpoint("timeout");
    send(8'h08, 3); send(8'h03, 3); send(8'h04, 3);
    checkpoint("after_timeout");

    send(8'h08, TIMEOUT); send(8'h01, TIMEOUT); send(8'h02, 3);
    checkpoint("boundary_accept");

    send(8'h08, 3); send(8'h07, TIMEOUT + 1); send(8'h01, 3);
    checkpoint("boundary_expire");

    en = 1'b0;
    send(8'h08, 3); send(8'h01, 3); send(8'h01, 3);
    checkpoint("en_low");

    en = 1'b1;
    send(8'h2B, 3); send(8'h11, 3);
    do_reset();
    send(8'h0C, 3); send(8'h22, 3); send(8'h33, 3);
    checkpoint("after_reset");

    for (int i = 0; i < 200; i++) begin
      d = 8'($urandom);
      en = ($urandom_range(0, 4) != 0);
      send(d, ($urandom_range(0, 9) == 0) ? $urandom_range(TIMEOUT - 1, TIMEOUT + 2)
                                          : $urandom_range(2, 6));
    end
    en = 1'b1;
    checkpoint("random");

    for (int i = 0; i < 300; i++) begin
      d = 8'($urandom) & 8'hF7;
      send(d, 2);
    end
    checkpoint("saturate");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
